// File: rtl/decode_pkg.sv
// decode_pkg: constants shared by the RV32I decode stage and its decoder.
//   ALU function codes, opcode/funct7 encodings, instruction formats,
//   pipeline state encoding, and the field values for bubbles/illegals.
//   No ports (package).
package decode_pkg;

  localparam int ALU_FUNCT_W = 5;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_SLL   = 5'd2;
  localparam logic [4:0] ALU_SLT   = 5'd3;
  localparam logic [4:0] ALU_SLTU  = 5'd4;
  localparam logic [4:0] ALU_XOR   = 5'd5;
  localparam logic [4:0] ALU_SRL   = 5'd6;
  localparam logic [4:0] ALU_SRA   = 5'd7;
  localparam logic [4:0] ALU_OR    = 5'd8;
  localparam logic [4:0] ALU_AND   = 5'd9;
  localparam logic [4:0] ALU_PASSB = 5'd10;
  // M-extension codes are ALU_M_BASE + funct3 (MUL .. REMU)
  localparam logic [4:0] ALU_M_BASE = 5'd16;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_t;

  // Bubbles and illegal instructions both look like addi x0,x0,0
  localparam logic [4:0] BUBBLE_FUNCT  = ALU_ADD;
  localparam fmt_t       BUBBLE_FMT    = FMT_I;
  localparam logic [4:0] ILLEGAL_FUNCT = ALU_ADD;
  localparam fmt_t       ILLEGAL_FMT   = FMT_I;

  // Encoded as occupancy of {output register, skid buffer}
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_TWO   = 2'b11
  } stage_state_t;

  function automatic logic [4:0] alu_from_funct3(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv_decode_comb.sv
// rv_decode_comb: purely combinational RV32I instruction decoder.
//   in : instr[31:0]
//   out: funct (ALU code), rs1/rs2/rd, imm (sign-extended to XLEN),
//        fmt (R/I/S/B/U/J), illegal
// Build option: DECODE_M_EXT_EN enables decode of the M extension
//   (OP with funct7=0000001); without it that encoding is illegal.
module rv_decode_comb #(
  parameter int XLEN        = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int ALU_FUNCT_W = 5
) (
  input  logic [31:0]            instr,
  output logic [ALU_FUNCT_W-1:0] funct,
  output logic [REG_ADDR_W-1:0]  rs1,
  output logic [REG_ADDR_W-1:0]  rs2,
  output logic [REG_ADDR_W-1:0]  rd,
  output logic [XLEN-1:0]        imm,
  output logic [2:0]             fmt,
  output logic                   illegal
);
  import decode_pkg::*;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [4:0]  alu;
  fmt_t        fmt_d;
  logic [31:0] imm32;
  logic        bad;
  logic        use_rs1, use_rs2, use_rd;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};

  always_comb begin
    alu   = ALU_ADD;
    fmt_d = FMT_I;
    imm32 = '0;
    bad   = 1'b0;
    case (opcode)
      OPC_LUI: begin
        fmt_d = FMT_U;
        alu   = ALU_PASSB;
        imm32 = {instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        fmt_d = FMT_U;
        imm32 = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        fmt_d = FMT_J;
        imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_JALR: begin
        imm32 = imm_i;
        bad   = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        fmt_d = FMT_B;
        imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        case (f3[2:1])
          2'b00:   alu = ALU_SUB;
          2'b10:   alu = ALU_SLT;
          2'b11:   alu = ALU_SLTU;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        imm32 = imm_i;
        bad   = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        fmt_d = FMT_S;
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        bad   = f3[2] || (f3 == 3'b011);
      end
      OPC_OPIMM: begin
        imm32 = imm_i;
        alu   = alu_from_funct3(f3);
        // only the shift-immediates constrain the upper bits
        if (f3 == 3'b001 && f7 != F7_BASE) bad = 1'b1;
        if (f3 == 3'b101) begin
          if (f7 == F7_ALT)       alu = ALU_SRA;
          else if (f7 != F7_BASE) bad = 1'b1;
        end
      end
      OPC_OP: begin
        fmt_d = FMT_R;
        if (f7 == F7_BASE)                     alu = alu_from_funct3(f3);
        else if (f7 == F7_ALT && f3 == 3'b000) alu = ALU_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101) alu = ALU_SRA;
`ifdef DECODE_M_EXT_EN
        else if (f7 == F7_MULDIV)              alu = ALU_M_BASE + {2'b00, f3};
`endif
        else                                   bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) bad = 1'b1;
  end

  always_comb begin
    use_rs1 = (fmt_d == FMT_R) || (fmt_d == FMT_I) || (fmt_d == FMT_S) || (fmt_d == FMT_B);
    use_rs2 = (fmt_d == FMT_R) || (fmt_d == FMT_S) || (fmt_d == FMT_B);
    use_rd  = (fmt_d == FMT_R) || (fmt_d == FMT_I) || (fmt_d == FMT_U) || (fmt_d == FMT_J);
  end

  assign illegal = bad;
  assign funct   = bad ? ALU_FUNCT_W'(ILLEGAL_FUNCT) : ALU_FUNCT_W'(alu);
  assign fmt     = bad ? ILLEGAL_FMT : fmt_d;
  assign rs1     = (!bad && use_rs1) ? REG_ADDR_W'(instr[19:15]) : '0;
  assign rs2     = (!bad && use_rs2) ? REG_ADDR_W'(instr[24:20]) : '0;
  assign rd      = (!bad && use_rd)  ? REG_ADDR_W'(instr[11:7])  : '0;
  assign imm     = bad ? '0 : XLEN'($signed(imm32));

endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered valid/ready RV32I decode stage with a
//   1-entry skid buffer, flush and bubble insertion. XLEN must be >= 32.
//   clk, rst_n (async, active low), flush, ctrl_override
//   in_valid/in_ready/in_instr/in_pc        : fetch side
//   out_valid/out_ready/out_alu_funct/out_rs1/out_rs2/out_rd/out_imm/
//   out_fmt/out_illegal/out_pc              : execute side
// Build option: DECODE_M_EXT_EN (passed through to rv_decode_comb).
//
// state    | meaning
// ST_EMPTY | nothing held
// ST_ONE   | output register holds a result, skid buffer empty
// ST_TWO   | output register full and one raw instruction in skid buffer
module instr_decode_stage #(
  parameter int XLEN        = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int ALU_FUNCT_W = decode_pkg::ALU_FUNCT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   ctrl_override,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [XLEN-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ALU_FUNCT_W-1:0] out_alu_funct,
  output logic [REG_ADDR_W-1:0]  out_rs1,
  output logic [REG_ADDR_W-1:0]  out_rs2,
  output logic [REG_ADDR_W-1:0]  out_rd,
  output logic [XLEN-1:0]        out_imm,
  output logic [2:0]             out_fmt,
  output logic                   out_illegal,
  output logic [XLEN-1:0]        out_pc
);
  import decode_pkg::*;

  stage_state_t state_q, state_d;

  logic [31:0]     sb_instr;
  logic [XLEN-1:0] sb_pc;
  logic            sb_ovr;
  logic            sb_full;
  logic            accept, out_xfer, load_or, load_sb;

  logic [31:0]            src_instr;
  logic [XLEN-1:0]        src_pc;
  logic                   src_ovr;
  logic [ALU_FUNCT_W-1:0] dec_funct;
  logic [REG_ADDR_W-1:0]  dec_rs1, dec_rs2, dec_rd;
  logic [XLEN-1:0]        dec_imm;
  logic [2:0]             dec_fmt;
  logic                   dec_illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_ONE;
        ST_ONE: begin
          if (accept && !out_xfer)      state_d = ST_TWO;
          else if (!accept && out_xfer) state_d = ST_EMPTY;
        end
        ST_TWO:   if (out_xfer) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // in_ready depends only on state, so out_ready never reaches it combinationally
  always_comb begin
    sb_full   = (state_q == ST_TWO);
    in_ready  = !sb_full;
    out_valid = (state_q != ST_EMPTY);
    load_or   = 1'b0;
    load_sb   = 1'b0;
    if (!flush) begin
      case (state_q)
        ST_EMPTY: load_or = accept;
        ST_ONE: begin
          load_or = accept && out_ready;
          load_sb = accept && !out_ready;
        end
        ST_TWO:   load_or = out_ready;
        default: ;
      endcase
    end
  end

  assign accept   = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // With the skid buffer occupied it is always the oldest instruction
  assign src_instr = sb_full ? sb_instr : in_instr;
  assign src_pc    = sb_full ? sb_pc    : in_pc;
  assign src_ovr   = sb_full ? sb_ovr   : ctrl_override;

  rv_decode_comb #(
    .XLEN        (XLEN),
    .REG_ADDR_W  (REG_ADDR_W),
    .ALU_FUNCT_W (ALU_FUNCT_W)
  ) u_dec (
    .instr   (src_instr),
    .funct   (dec_funct),
    .rs1     (dec_rs1),
    .rs2     (dec_rs2),
    .rd      (dec_rd),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_instr <= '0;
      sb_pc    <= '0;
      sb_ovr   <= 1'b0;
    end else if (load_sb) begin
      sb_instr <= in_instr;
      sb_pc    <= in_pc;
      sb_ovr   <= ctrl_override;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_alu_funct <= '0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_rd        <= '0;
      out_imm       <= '0;
      out_fmt       <= '0;
      out_illegal   <= 1'b0;
      out_pc        <= '0;
    end else if (load_or) begin
      if (src_ovr) begin
        out_alu_funct <= ALU_FUNCT_W'(BUBBLE_FUNCT);
        out_rs1       <= '0;
        out_rs2       <= '0;
        out_rd        <= '0;
        out_imm       <= '0;
        out_fmt       <= BUBBLE_FMT;
        out_illegal   <= 1'b0;
      end else begin
        out_alu_funct <= dec_funct;
        out_rs1       <= dec_rs1;
        out_rs2       <= dec_rs2;
        out_rd        <= dec_rd;
        out_imm       <= dec_imm;
        out_fmt       <= dec_fmt;
        out_illegal   <= dec_illegal;
      end
      out_pc <= src_pc;
    end
  end

endmodule

// File: tb/tb_instr_decode_stage.sv
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, ctrl_override, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_imm, out_pc;
  logic [4:0]  out_alu_funct, out_rs1, out_rs2, out_rd;
  logic [2:0]  out_fmt;
  logic        out_illegal;

  int checks = 0;
  int failures = 0;

  instr_decode_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .ctrl_override (ctrl_override),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_alu_funct (out_alu_funct),
    .out_rs1       (out_rs1),
    .out_rs2       (out_rs2),
    .out_rd        (out_rd),
    .out_imm       (out_imm),
    .out_fmt       (out_fmt),
    .out_illegal   (out_illegal),
    .out_pc        (out_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          funct;
    int          rs1;
    int          rs2;
    int          rd;
    logic [31:0] imm;
    int          fmt;
    bit          fmt_known;
    bit          illegal;
    logic [31:0] pc;
  } exp_t;

  // legality / ALU-code lookup keyed by funct3*256 + funct7
  int op_tab[int];
  int opi_tab[int];
  int br_tab[int];
  exp_t q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    int   opc, f3, f7, k, sx, sgn, iimm, shi;
    bit   ok;
    e = '{default: 0};
    e.fmt_known = 1;
    opc  = int'(ins & 32'h7f);
    f3   = int'((ins >> 12) & 32'h7);
    f7   = int'((ins >> 25) & 32'h7f);
    sx   = int'(ins);
    sgn  = sx >>> 31;
    iimm = sx >>> 20;
    shi  = sx >>> 25;
    ok   = 1;
    case (opc)
      'h37: begin e.fmt = 4; e.funct = 10; e.imm = ins & 32'hFFFFF000; end
      'h17: begin e.fmt = 4; e.funct = 0;  e.imm = ins & 32'hFFFFF000; end
      'h6f: begin
        e.fmt = 5;
        e.imm = 32'(sgn << 20) | (((ins >> 12) & 32'hff) << 12) |
                (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3ff) << 1);
      end
      'h67: begin e.fmt = 1; ok = (f3 == 0); e.imm = 32'(iimm); end
      'h63: begin
        e.fmt = 3;
        ok = br_tab.exists(f3);
        if (ok) e.funct = br_tab[f3];
        e.imm = 32'(sgn << 12) | (((ins >> 7) & 32'h1) << 11) |
                (((ins >> 25) & 32'h3f) << 5) | (((ins >> 8) & 32'hf) << 1);
      end
      'h03: begin e.fmt = 1; ok = (f3 inside {0, 1, 2, 4, 5}); e.imm = 32'(iimm); end
      'h23: begin e.fmt = 2; ok = (f3 <= 2); e.imm = 32'(shi << 5) | ((ins >> 7) & 32'h1f); end
      'h13: begin
        e.fmt = 1;
        k = f3 * 256 + ((f3 == 1 || f3 == 5) ? f7 : 0);
        ok = opi_tab.exists(k);
        if (ok) e.funct = opi_tab[k];
        e.imm = 32'(iimm);
      end
      'h33: begin
        e.fmt = 0;
        k = f3 * 256 + f7;
        ok = op_tab.exists(k);
        if (ok) e.funct = op_tab[k];
      end
      default: ok = 0;
    endcase
    if (e.fmt <= 3)                  e.rs1 = int'(ins[19:15]);
    if (e.fmt == 0 || e.fmt == 2 || e.fmt == 3) e.rs2 = int'(ins[24:20]);
    if (e.fmt inside {0, 1, 4, 5})   e.rd  = int'(ins[11:7]);
    if (!ok) begin
      e = '{default: 0};
      e.fmt = 1;
      e.fmt_known = 1;
      e.illegal = 1;
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [6:0]  opcs [9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
    int          p;
    r = $urandom();
    p = $urandom_range(0, 10);
    if (p < 9) r[6:0] = opcs[p];
    else if (p == 9) r[6:0] = 7'h33;
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      2: r[31:25] = 7'h01;
      default: ;
    endcase
    return r;
  endfunction

  task automatic chk_entry(input string tag, input exp_t e);
    chk({tag, "_funct"},   64'(out_alu_funct), 64'(e.funct));
    chk({tag, "_rs1"},     64'(out_rs1),       64'(e.rs1));
    chk({tag, "_rs2"},     64'(out_rs2),       64'(e.rs2));
    chk({tag, "_rd"},      64'(out_rd),        64'(e.rd));
    chk({tag, "_imm"},     64'(out_imm),       64'(e.imm));
    chk({tag, "_illegal"}, 64'(out_illegal),   64'(e.illegal));
    chk({tag, "_pc"},      64'(out_pc),        64'(e.pc));
    if (e.fmt_known) chk({tag, "_fmt"}, 64'(out_fmt), 64'(e.fmt));
  endtask

  task automatic send1(input logic [31:0] ins, input logic [31:0] pc, input logic ovr);
    in_valid = 1'b1; in_instr = ins; in_pc = pc; ctrl_override = ovr;
    @(negedge clk);
    in_valid = 1'b0; ctrl_override = 1'b0;
  endtask

  initial begin
    int   base [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    exp_t e;
    bit   acc, xf;

    for (int i = 0; i < 8; i++) begin
      op_tab[i * 256]  = base[i];
      opi_tab[i * 256] = base[i];
`ifdef DECODE_M_EXT_EN
      op_tab[i * 256 + 1] = 16 + i;
`endif
    end
    op_tab[0 * 256 + 'h20]  = 1;
    op_tab[5 * 256 + 'h20]  = 7;
    opi_tab[5 * 256 + 'h20] = 7;
    br_tab[0] = 1; br_tab[1] = 1; br_tab[4] = 3; br_tab[5] = 3; br_tab[6] = 4; br_tab[7] = 4;

    rst_n = 1'b0; flush = 1'b0; ctrl_override = 1'b0; in_valid = 1'b0;
    in_instr = '0; in_pc = '0; out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 64'(out_valid),   64'd0);
    chk("rst_in_ready",  64'(in_ready),    64'd1);
    chk("rst_rd",        64'(out_rd),      64'd0);
    chk("rst_imm",       64'(out_imm),     64'd0);
    chk("rst_illegal",   64'(out_illegal), 64'd0);
    chk("rst_pc",        64'(out_pc),      64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // single addi
    @(negedge clk);
    out_ready = 1'b1;
    send1(32'h00500093, 32'h100, 1'b0);
    chk("addi_valid", 64'(out_valid),     64'd1);
    chk("addi_funct", 64'(out_alu_funct), 64'd0);
    chk("addi_rs1",   64'(out_rs1),       64'd0);
    chk("addi_rd",    64'(out_rd),        64'd1);
    chk("addi_imm",   64'(out_imm),       64'd5);
    chk("addi_fmt",   64'(out_fmt),       64'd1);
    chk("addi_pc",    64'(out_pc),        64'h100);
    @(negedge clk);
    chk("addi_drained", 64'(out_valid), 64'd0);

    // stall and skid
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h402081B3; in_pc = 32'h200;
    @(negedge clk);
    chk("skid_ready_one", 64'(in_ready), 64'd1);
    in_instr = 32'hFE20AE23; in_pc = 32'h204;
    @(negedge clk);
    in_valid = 1'b0;
    chk("skid_ready_two", 64'(in_ready), 64'd0);
    e = '{funct: 1, rs1: 1, rs2: 2, rd: 3, imm: 32'h0, fmt: 0, fmt_known: 1, illegal: 0, pc: 32'h200};
    chk_entry("sub", e);
    @(negedge clk);
    chk_entry("sub_hold", e);
    out_ready = 1'b1;
    @(negedge clk);
    e = '{funct: 0, rs1: 1, rs2: 2, rd: 0, imm: 32'hFFFFFFFC, fmt: 2, fmt_known: 1, illegal: 0, pc: 32'h204};
    chk_entry("sw", e);
    chk("sw_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("skid_drained", 64'(out_valid), 64'd0);

    // lui
    send1(32'h123452B7, 32'h300, 1'b0);
    e = '{funct: 10, rs1: 0, rs2: 0, rd: 5, imm: 32'h12345000, fmt: 4, fmt_known: 1, illegal: 0, pc: 32'h300};
    chk_entry("lui", e);
    @(negedge clk);

    // illegal
    send1(32'hFFFFFFFF, 32'h304, 1'b0);
    e = '{funct: 0, rs1: 0, rs2: 0, rd: 0, imm: 32'h0, fmt: 1, fmt_known: 1, illegal: 1, pc: 32'h304};
    chk_entry("illegal", e);
    @(negedge clk);

    // mul x1,x2,x3
    send1(32'h023100B3, 32'h308, 1'b0);
`ifdef DECODE_M_EXT_EN
    e = '{funct: 16, rs1: 2, rs2: 3, rd: 1, imm: 32'h0, fmt: 0, fmt_known: 1, illegal: 0, pc: 32'h308};
`else
    e = '{funct: 0, rs1: 0, rs2: 0, rd: 0, imm: 32'h0, fmt: 1, fmt_known: 1, illegal: 1, pc: 32'h308};
`endif
    chk_entry("mul", e);
    @(negedge clk);

    // override -> bubble with pc kept
    send1(32'h00500093, 32'h30C, 1'b1);
    e = '{funct: 0, rs1: 0, rs2: 0, rd: 0, imm: 32'h0, fmt: 1, fmt_known: 0, illegal: 0, pc: 32'h30C};
    chk_entry("bubble", e);
    @(negedge clk);

    // flush with two held, input in the flush cycle is dropped
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100113; in_pc = 32'h400;
    @(negedge clk);
    in_pc = 32'h404;
    @(negedge clk);
    chk("flush_pre_ready", 64'(in_ready), 64'd0);
    flush = 1'b1; in_pc = 32'h408;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready),  64'd1);
    @(negedge clk);
    chk("flush_dropped", 64'(out_valid), 64'd0);

    // async reset mid-stall
    in_valid = 1'b1; in_instr = 32'h402081B3; in_pc = 32'h500;
    @(negedge clk);
    in_pc = 32'h504;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst2_pre_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_valid", 64'(out_valid),     64'd0);
    chk("rst2_ready", 64'(in_ready),      64'd1);
    chk("rst2_funct", 64'(out_alu_funct), 64'd0);
    chk("rst2_rs1",   64'(out_rs1),       64'd0);
    chk("rst2_rs2",   64'(out_rs2),       64'd0);
    chk("rst2_rd",    64'(out_rd),        64'd0);
    chk("rst2_pc",    64'(out_pc),        64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic against the queue model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      chk("rnd_in_ready",  64'(in_ready),  64'(q.size() < 2));
      chk("rnd_out_valid", 64'(out_valid), 64'(q.size() > 0));
      if (q.size() > 0) chk_entry("rnd", q[0]);
      in_valid      = ($urandom_range(0, 99) < 60);
      in_instr      = gen_instr();
      in_pc         = $urandom() & 32'hFFFFFFFC;
      ctrl_override = ($urandom_range(0, 99) < 8);
      out_ready     = ($urandom_range(0, 99) < 55);
      flush         = ($urandom_range(0, 99) < 4);
      @(posedge clk);
      acc = in_valid && (q.size() < 2);
      xf  = out_ready && (q.size() > 0);
      if (flush) begin
        q.delete();
      end else begin
        if (xf) void'(q.pop_front());
        if (acc) begin
          if (ctrl_override) e = '{funct: 0, rs1: 0, rs2: 0, rd: 0, imm: 32'h0, fmt: 1,
                                   fmt_known: 0, illegal: 0, pc: 32'h0};
          else               e = model(in_instr);
          e.pc = in_pc;
          q.push_back(e);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
